// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: upstream feeder for a serial configuration chain.
// Takes the configuration image as parallel words over valid/ready and
// shifts it out MSB-first on config_en/config_in. It emits exactly CHAIN_LEN
// shift cycles per load and then pulses done once.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             one-cycle load request, honoured only in IDLE
//   abort             synchronous abandon of the current load
//   word_valid/ready  parallel word handshake (word_data, MSB streamed first)
//   config_en         chain shift enable
//   config_in         serial bit into the chain
//   config_out        serial bit returning from the chain end (readback only)
//   busy              high in any state other than IDLE
//   done              one-cycle pulse after the last bit is shifted
//   rb_valid/rb_data  previous chain image, one word per pulse (readback only)
//
// Optional feature: define CFG_CHAIN_READBACK_EN to capture the image being
// shifted out of the chain end and present it as words on rb_valid/rb_data.
module cfg_chain_loader #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 34
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              config_en,
    output logic              config_in,
    input  logic              config_out,
    output logic              busy,
    output logic              done
`ifdef CFG_CHAIN_READBACK_EN
    ,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data
`endif
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WB_W  = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_WORD = 2'd1,
        S_SHIFT     = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [WB_W-1:0]   wbits_q, wbits_d;

    logic word_ready_d, config_en_d, config_in_d, busy_d, done_d;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        rem_d   = rem_q;
        wbits_d = wbits_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_WORD;
                    rem_d   = CNT_W'(CHAIN_LEN);
                end
            end
            S_WAIT_WORD: begin
                // word_ready is high throughout WAIT_WORD, so word_valid alone
                // completes the handshake here.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (word_valid) begin
                    shreg_d = word_data;
                    // The final word may be partial; only its upper bits go out.
                    wbits_d = (32'(rem_q) < WORD_W) ? WB_W'(rem_q) : WB_W'(WORD_W);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d = shreg_q << 1;
                rem_d   = rem_q - CNT_W'(1);
                wbits_d = wbits_q - WB_W'(1);
                if (abort) begin
                    state_d = S_IDLE;
                end else if (rem_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end else if (wbits_q == WB_W'(1)) begin
                    state_d = S_WAIT_WORD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered images of the next state, so they are
        // cycle-aligned with the state register and never combinational.
        word_ready_d = (state_d == S_WAIT_WORD);
        config_en_d  = (state_d == S_SHIFT);
        config_in_d  = (state_d == S_SHIFT) && shreg_d[WORD_W-1];
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            rem_q      <= '0;
            wbits_q    <= '0;
            word_ready <= 1'b0;
            config_en  <= 1'b0;
            config_in  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            rem_q      <= rem_d;
            wbits_q    <= wbits_d;
            word_ready <= word_ready_d;
            config_en  <= config_en_d;
            config_in  <= config_in_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

`ifdef CFG_CHAIN_READBACK_EN
    logic [WORD_W-1:0] rb_cap_q, rb_cap_d;
    logic [WB_W-1:0]   rb_cnt_q, rb_cnt_d;
    logic              rb_valid_d;
    logic [WORD_W-1:0] rb_data_d;

    // Capture the old image leaving the chain end, left-aligned per word
    always_comb begin
        rb_cap_d   = rb_cap_q;
        rb_cnt_d   = rb_cnt_q;
        rb_valid_d = 1'b0;
        rb_data_d  = rb_data;

        if (abort && (state_q != S_IDLE)) begin
            rb_cap_d = '0;
            rb_cnt_d = '0;
        end else if (state_q == S_SHIFT) begin
            // config_out still holds the pre-shift chain end during this cycle.
            rb_cap_d = rb_cap_q | (WORD_W'(config_out) << (WB_W'(WORD_W - 1) - rb_cnt_q));
            rb_cnt_d = rb_cnt_q + WB_W'(1);
            // Readback groups line up with input words, including the partial one.
            if (wbits_q == WB_W'(1)) begin
                rb_valid_d = 1'b1;
                rb_data_d  = rb_cap_d;
                rb_cap_d   = '0;
                rb_cnt_d   = '0;
            end
        end
    end

    // Readback registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rb_cap_q <= '0;
            rb_cnt_q <= '0;
            rb_valid <= 1'b0;
            rb_data  <= '0;
        end else begin
            rb_cap_q <= rb_cap_d;
            rb_cnt_q <= rb_cnt_d;
            rb_valid <= rb_valid_d;
            rb_data  <= rb_data_d;
        end
    end
`else
    // Without readback the returning chain bit has no consumer.
    logic unused_config_out;
    assign unused_config_out = config_out;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: directed-plus-random bench for cfg_chain_loader.
// It models the downstream chain as a plain shift register. Expected bit
// streams, chain images, word counts and timing are derived from the word
// image with simple arithmetic.
module tb_cfg_chain_loader;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned CHAIN_LEN = 34;
    localparam int unsigned N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;

    logic              clk        = 1'b0;
    logic              reset      = 1'b0;
    logic              start      = 1'b0;
    logic              abort      = 1'b0;
    logic              word_valid = 1'b0;
    logic [WORD_W-1:0] word_data  = '0;
    logic              word_ready;
    logic              config_en;
    logic              config_in;
    logic              config_out;
    logic              busy;
    logic              done;
`ifdef CFG_CHAIN_READBACK_EN
    logic              rb_valid;
    logic [WORD_W-1:0] rb_data;
`endif

    logic [CHAIN_LEN-1:0] chain = '0;
    logic [WORD_W-1:0]    img [N_WORDS];
    int                   n_asserts = 0;
    int                   n_fail    = 0;

    cfg_chain_loader #(
        .WORD_W    (WORD_W),
        .CHAIN_LEN (CHAIN_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out),
        .busy       (busy),
        .done       (done)
`ifdef CFG_CHAIN_READBACK_EN
        ,
        .rb_valid   (rb_valid),
        .rb_data    (rb_data)
`endif
    );

    always #5 clk = ~clk;

    // Downstream chain: the last flop drives config_out
    assign config_out = chain[CHAIN_LEN-1];
    always @(posedge clk) begin
        if (config_en) chain <= {chain[CHAIN_LEN-2:0], config_in};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit k of the load stream: words in order, each MSB first
    function automatic logic exp_bit(input int k);
        logic [WORD_W-1:0] w;
        w = img[k / WORD_W];
        return w[WORD_W - 1 - (k % WORD_W)];
    endfunction

    // First bit shifted ends deepest (chain MSB)
    function automatic logic [CHAIN_LEN-1:0] exp_chain();
        logic [CHAIN_LEN-1:0] v;
        v = '0;
        for (int k = 0; k < CHAIN_LEN; k++) v[CHAIN_LEN-1-k] = exp_bit(k);
        return v;
    endfunction

`ifdef CFG_CHAIN_READBACK_EN
    // Readback group g of an old chain image, left-aligned
    function automatic logic [WORD_W-1:0] exp_rb(input logic [CHAIN_LEN-1:0] prev, input int g);
        logic [WORD_W-1:0] v;
        v = '0;
        for (int j = 0; j < WORD_W; j++) begin
            int k;
            k = g * WORD_W + j;
            if (k < CHAIN_LEN) v[WORD_W-1-j] = prev[CHAIN_LEN-1-k];
        end
        return v;
    endfunction
`endif

    task automatic randomize_img();
        for (int i = 0; i < N_WORDS; i++) img[i] = WORD_W'($urandom);
    endtask

    // One load of img, called at a negedge with the DUT idle.
    // gap_word/gap_len: withhold word_valid before that word.
    // abort_word/abort_shift: abort on that shift cycle of that word.
    // busy_start_bit: pulse start after that many bits have shifted.
    task automatic do_load(input int gap_word, input int gap_len, input int abort_word,
                           input int abort_shift, input int busy_start_bit);
        int bits      = 0;
        int accepted  = 0;
        int dones     = 0;
        int done_cyc  = -1;
        int last_en   = -1;
        int abort_cyc = -1;
        int gap_left  = gap_len;
        int in_word   = 0;
        bit finished  = 1'b0;
        bit expect_en = 1'b0;
`ifdef CFG_CHAIN_READBACK_EN
        logic [CHAIN_LEN-1:0] prev_chain;
        logic [WORD_W-1:0]    rbq[$];
        prev_chain = chain;
`endif
        start      = 1'b1;
        abort      = 1'b0;
        word_valid = 1'b1;
        word_data  = img[0];
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            if (abort_cyc >= 0) begin
                check("abort_config_en_low", 64'(config_en), 64'(0));
                check("abort_busy_low", 64'(busy), 64'(0));
                check("abort_ready_low", 64'(word_ready), 64'(0));
                check("abort_no_done", 64'(done), 64'(0));
                if (cyc >= abort_cyc + 4) finished = 1'b1;
            end else begin
`ifdef CFG_CHAIN_READBACK_EN
                if (rb_valid) rbq.push_back(rb_data);
`endif
                if (expect_en) begin
                    check("first_en_after_handshake", 64'(config_en), 64'(1));
                    expect_en = 1'b0;
                end
                if (gap_left < gap_len && gap_left > 0) begin
                    check("gap_ready_held", 64'(word_ready), 64'(1));
                    check("gap_no_shift", 64'(config_en), 64'(0));
                end
                if (done) begin
                    dones++;
                    done_cyc = cyc;
                end
                if (config_en) begin
                    check($sformatf("stream_bit%0d", bits), 64'(config_in), 64'(exp_bit(bits)));
                    bits++;
                    in_word++;
                    last_en = cyc;
                end
                if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                    check("busy_low_after_done", 64'(busy), 64'(0));
                    check("ready_low_after_done", 64'(word_ready), 64'(0));
                    finished = 1'b1;
                end
            end
            // Inputs for the next edge
            start = (busy_start_bit >= 0) && config_en && (bits == busy_start_bit);
            abort = 1'b0;
            if (abort_cyc < 0 && abort_word >= 0 && config_en &&
                accepted - 1 == abort_word && in_word == abort_shift) begin
                abort     = 1'b1;
                abort_cyc = cyc;
            end
            word_valid = 1'b1;
            if (word_ready && accepted == gap_word && gap_left > 0) begin
                word_valid = 1'b0;
                gap_left--;
            end
            word_data = (accepted < N_WORDS) ? img[accepted] : '0;
            if (word_ready && word_valid) begin
                accepted++;
                in_word   = 0;
                expect_en = 1'b1;
            end
            if (!finished) @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        check("load_finished", 64'(finished), 64'(1));
        if (abort_word >= 0) begin
            check("abort_bits_shifted", 64'(bits), 64'(abort_word * WORD_W + abort_shift));
            check("abort_done_count", 64'(dones), 64'(0));
        end else begin
            check("total_shifts", 64'(bits), 64'(CHAIN_LEN));
            check("words_accepted", 64'(accepted), 64'(N_WORDS));
            check("done_count", 64'(dones), 64'(1));
            check("done_after_last_bit", 64'(done_cyc), 64'(last_en + 1));
            check("done_cycle", 64'(done_cyc), 64'(CHAIN_LEN + N_WORDS + gap_len + 1));
            check("chain_image", 64'(chain), 64'(exp_chain()));
`ifdef CFG_CHAIN_READBACK_EN
            check("rb_count", 64'(rbq.size()), 64'(N_WORDS));
            for (int g = 0; g < N_WORDS && g < rbq.size(); g++)
                check($sformatf("rb_word%0d", g), 64'(rbq[g]), 64'(exp_rb(prev_chain, g)));
`endif
        end
    endtask

    initial begin
        int sh;

        // Async reset before any clock edge
        #2 reset = 1'b1;
        #1;
        check("rst_word_ready", 64'(word_ready), 64'(0));
        check("rst_config_en", 64'(config_en), 64'(0));
        check("rst_config_in", 64'(config_in), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
`ifdef CFG_CHAIN_READBACK_EN
        check("rst_rb_valid", 64'(rb_valid), 64'(0));
        check("rst_rb_data", 64'(rb_data), 64'(0));
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // word_valid in IDLE is ignored
        word_valid = 1'b1;
        word_data  = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready_low", 64'(word_ready), 64'(0));
            check("idle_busy_low", 64'(busy), 64'(0));
            check("idle_no_shift", 64'(config_en), 64'(0));
        end

        // Directed image, back-to-back then with a 5-cycle stall before word 2
        img[0] = 8'hA5; img[1] = 8'h3C; img[2] = 8'hFF; img[3] = 8'h00; img[4] = 8'hC0;
        do_load(-1, 0, -1, -1, -1);
        do_load(2, 5, -1, -1, -1);

        // start pulse while busy is ignored
        randomize_img();
        do_load(-1, 0, -1, -1, 12);

        // Abort on the 3rd shift of word 1, then a clean reload
        randomize_img();
        do_load(-1, 0, 1, 3, -1);
        do_load(-1, 0, -1, -1, -1);

        // Asynchronous reset in the middle of a shift cycle
        randomize_img();
        start      = 1'b1;
        word_valid = 1'b1;
        word_data  = img[0];
        @(negedge clk);
        start = 1'b0;
        sh = 0;
        for (int i = 0; i < 40 && sh < 3; i++) begin
            if (config_en) sh++;
            if (sh < 3) @(negedge clk);
        end
        check("rst_mid_reached_shift", 64'(sh), 64'(3));
        #2 reset = 1'b1;
        #1;
        check("rst_mid_config_en", 64'(config_en), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_word_ready", 64'(word_ready), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'(0));
        do_load(-1, 0, -1, -1, -1);

        // Random images with a random stall before a random word
        repeat (3) begin
            randomize_img();
            do_load(int'($urandom_range(0, N_WORDS - 1)), int'($urandom_range(1, 6)), -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
